// File: rtl/weighted_rr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Holds the state enum, the width helpers and the rotated first-set search.
package weighted_rr_arb_pkg;

  localparam int unsigned MaxAgents = 16;
  localparam int unsigned MaxIdxW   = 4;

  typedef enum logic {StIdle, StOwned} arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // A disabled watchdog still gets a 1-bit counter so the register is never zero-width
  function automatic int unsigned hold_width(input int unsigned max_hold);
    return (max_hold == 0) ? 1 : $clog2(max_hold + 1);
  endfunction

  // First set bit of req searching upward from ptr+1, wrapping modulo n
  function automatic logic [MaxIdxW-1:0] rr_first_idx(input logic [MaxAgents-1:0] req,
                                                      input logic [MaxIdxW-1:0]   ptr,
                                                      input int unsigned          n);
    logic [MaxIdxW-1:0] idx;
    logic [31:0]        cand;
    logic               hit;
    idx = '0;
    hit = 1'b0;
    for (int unsigned k = 1; k <= MaxAgents; k++) begin
      if (k <= n) begin
        cand = (32'(ptr) + 32'(k)) % 32'(n);
        if (!hit && req[cand[MaxIdxW-1:0]]) begin
          hit = 1'b1;
          idx = cand[MaxIdxW-1:0];
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/weighted_rr_arbiter_pick.sv
// Combinational rotating-priority picker: first requester above ptr, wrapping.
module rr_priority_pick
  import weighted_rr_arb_pkg::*;
#(
  parameter int unsigned NumOfAgents = 4,
  parameter int unsigned IdxW        = 2
) (
  input  logic [NumOfAgents-1:0] req,
  input  logic [IdxW-1:0]        ptr,
  output logic                   found,
  output logic [IdxW-1:0]        idx
);

  logic [MaxAgents-1:0] req_ext;
  logic [MaxIdxW-1:0]   ptr_ext;
  logic [MaxIdxW-1:0]   pick;

  always_comb begin
    req_ext                  = '0;
    req_ext[NumOfAgents-1:0] = req;
    ptr_ext                  = MaxIdxW'(ptr);
    pick                     = rr_first_idx(req_ext, ptr_ext, NumOfAgents);
    idx                      = pick[IdxW-1:0];
    found                    = |req;
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter for a multi-cycle shared resource. An owner keeps the
// grant for up to Weight[i] completed transactions, with a hold watchdog against stalls.
module weighted_rr_arbiter
  import weighted_rr_arb_pkg::*;
#(
  parameter int unsigned NumOfAgents = 4,
  parameter int unsigned WeightW     = 4,
  parameter int unsigned MaxHold     = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NumOfAgents-1:0]         In,
  input  logic [NumOfAgents*WeightW-1:0] Weight,
  input  logic                           Done,
  output logic [NumOfAgents-1:0]         Grant,
  output logic [$clog2(NumOfAgents)-1:0] GrantIdx,
  output logic                           TimeoutErr
);

  localparam int unsigned IdxW     = idx_width(NumOfAgents);
  localparam int unsigned HoldW    = hold_width(MaxHold);
  localparam bit          WdogEn   = (MaxHold != 0);
  localparam logic [HoldW-1:0] HoldLast = HoldW'((MaxHold == 0) ? 0 : MaxHold - 1);

  arb_state_e             state_q, state_d;
  logic [NumOfAgents-1:0] grant_q, grant_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [IdxW-1:0]        ptr_q, ptr_d;
  logic [WeightW-1:0]     credit_q, credit_d;
  logic [HoldW-1:0]       hold_q, hold_d;
  logic                   terr_q, terr_d;

  logic                   withdraw, timeout, done_ev, keep, release_ev;
  logic [WeightW-1:0]     credit_left, new_weight, fresh_credit;
  logic [NumOfAgents-1:0] pick_req;
  logic [IdxW-1:0]        pick_ptr, pick_idx;
  logic                   pick_found;

  rr_priority_pick #(
    .NumOfAgents (NumOfAgents),
    .IdxW        (IdxW)
  ) u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    withdraw    = (state_q == StOwned) && !In[idx_q];
    timeout     = (state_q == StOwned) && !withdraw && WdogEn && (hold_q == HoldLast);
    done_ev     = (state_q == StOwned) && Done && !withdraw && !timeout;
    credit_left = credit_q - 1'b1;
    // Owner's request is known high here, otherwise withdraw would have fired
    keep        = done_ev && (credit_left != '0);
    release_ev  = withdraw || timeout || (done_ev && !keep);

    pick_ptr = release_ev ? idx_q : ptr_q;
    pick_req = In;
    // A credit-exhausted owner stays eligible so a sole requester is re-granted
    if (withdraw || timeout) begin
      pick_req[idx_q] = 1'b0;
    end

    new_weight   = Weight[pick_idx*WeightW +: WeightW];
    fresh_credit = (new_weight == '0) ? WeightW'(1) : new_weight;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    hold_d   = hold_q;
    terr_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d           = StOwned;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          idx_d             = pick_idx;
          credit_d          = fresh_credit;
          hold_d            = '0;
        end
      end
      StOwned: begin
        if (release_ev) begin
          ptr_d  = idx_q;
          terr_d = timeout;
          if (pick_found) begin
            grant_d           = '0;
            grant_d[pick_idx] = 1'b1;
            idx_d             = pick_idx;
            credit_d          = fresh_credit;
            hold_d            = '0;
          end else begin
            state_d = StIdle;
            grant_d = '0;
          end
        end else if (keep) begin
          credit_d = credit_left;
          hold_d   = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      idx_q    <= '0;
      ptr_q    <= IdxW'(NumOfAgents - 1);
      credit_q <= '0;
      hold_q   <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
      hold_q   <= hold_d;
      terr_q   <= terr_d;
    end
  end

  assign Grant      = grant_q;
  assign GrantIdx   = idx_q;
  assign TimeoutErr = terr_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Scoreboard bench for weighted_rr_arbiter: 4 agents, 4-bit weights, 8-cycle watchdog.
module tb_weighted_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_req;
  logic [15:0] weight;
  logic        done;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        terr;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string      tag;
    logic [3:0] g;
    logic       t;
  } exp_t;

  exp_t sb[$];

  logic [3:0] wt_seq [7] = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] rr_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  always #5 clk = ~clk;

  weighted_rr_arbiter #(
    .NumOfAgents (4),
    .WeightW     (4),
    .MaxHold     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .In         (in_req),
    .Weight     (weight),
    .Done       (done),
    .Grant      (grant),
    .GrantIdx   (grant_idx),
    .TimeoutErr (terr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] onehot_idx(input logic [3:0] v);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) r = 32'(i);
    end
    return r;
  endfunction

  // Queue the expectation for the coming edge, then compare once the edge has passed
  task automatic expect_edge(input string tag, input logic [3:0] g, input logic t);
    exp_t e;
    e.tag = tag;
    e.g   = g;
    e.t   = t;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq({e.tag, ".grant"}, 32'(grant), 32'(e.g));
    check_eq({e.tag, ".terr"}, 32'(terr), 32'(e.t));
    if (e.g != 4'b0000) begin
      check_eq({e.tag, ".idx"}, 32'(grant_idx), onehot_idx(e.g));
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    in_req = 4'b0000;
    weight = 16'h1111;
    done   = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("reset.grant", 32'(grant), 32'h0);
    check_eq("reset.terr", 32'(terr), 32'h0);
    check_eq("reset.idx", 32'(grant_idx), 32'h0);
    rst = 1'b0;

    // Reset priority: agent 0 first, then plain rotation with weight 1
    in_req = 4'b1111;
    expect_edge("rr_first", 4'b0001, 1'b0);
    done = 1'b1;
    for (int i = 0; i < 4; i++) expect_edge($sformatf("rr_%0d", i), rr_seq[i], 1'b0);
    done = 1'b0;

    // Weighting: agent0 x2, agent1 x3, agent2 x1, agent3 x1
    pulse_reset();
    weight = 16'h1132;
    expect_edge("wt_first", 4'b0001, 1'b0);
    done = 1'b1;
    for (int i = 0; i < 7; i++) expect_edge($sformatf("wt_%0d", i), wt_seq[i], 1'b0);
    done = 1'b0;

    // Withdrawal hands off directly to the next requester
    pulse_reset();
    weight = 16'h1111;
    in_req = 4'b1010;
    expect_edge("wd_grant", 4'b0010, 1'b0);
    in_req = 4'b1000;
    expect_edge("wd_handoff", 4'b1000, 1'b0);

    // Watchdog: agent 2 alone, no Done
    in_req = 4'b0000;
    expect_edge("wdog_idle", 4'b0000, 1'b0);
    in_req = 4'b0100;
    expect_edge("wdog_grant", 4'b0100, 1'b0);
    for (int i = 1; i < 8; i++) expect_edge($sformatf("wdog_hold%0d", i), 4'b0100, 1'b0);
    expect_edge("wdog_expire", 4'b0000, 1'b1);
    expect_edge("wdog_regrant", 4'b0100, 1'b0);

    // Sole requester keeps the grant across Done pulses, then idles
    done = 1'b1;
    for (int i = 0; i < 3; i++) expect_edge($sformatf("sole_%0d", i), 4'b0100, 1'b0);
    done   = 1'b0;
    in_req = 4'b0000;
    expect_edge("sole_release", 4'b0000, 1'b0);
    done = 1'b1;
    expect_edge("idle_done", 4'b0000, 1'b0);
    done = 1'b0;

    // Async reset while agent 3 is mid-burst with credit 2
    pulse_reset();
    weight = 16'h3111;
    in_req = 4'b1000;
    expect_edge("ar_grant", 4'b1000, 1'b0);
    done = 1'b1;
    expect_edge("ar_burst", 4'b1000, 1'b0);
    done = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_async.grant", 32'(grant), 32'h0);
    check_eq("ar_async.terr", 32'(terr), 32'h0);
    #1;
    rst    = 1'b0;
    in_req = 4'b1001;
    expect_edge("ar_after", 4'b0001, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/weighted_rr_arbiter.md
# weighted_rr_arbiter

Weighted round-robin arbiter that shares one multi-cycle resource among `NumOfAgents` requesters, granting an agent for up to `Weight[i]` consecutive transactions before rotating priority. Each grant is held until the owner signals transaction completion, the owner withdraws its request, or a hold watchdog expires. It sits in front of the shared resource and supersedes the single-cycle round-robin arbiter where requesters issue bursts.

## Interface
- `NumOfAgents`, 4: number of requesters, 2..16
- `WeightW`, 4: width of each per-agent weight field
- `MaxHold`, 64: maximum cycles a grant may be held without `Done`; 0 disables the watchdog
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  asynchronous, active-high reset
- `In`  in  NumOfAgents  per-agent request level; must stay high until own `Done`
- `Weight`  in  NumOfAgents*WeightW  packed weights, agent i at bits [i*WeightW +: WeightW]; sampled only when a new owner is granted
- `Done`  in  1  one-cycle pulse from the current owner: transaction complete
- `Grant`  out  NumOfAgents  registered one-hot0 grant
- `GrantIdx`  out  $clog2(NumOfAgents)  index of the current owner, valid when `|Grant`
- `TimeoutErr`  out  1  one-cycle pulse when the watchdog forces a release

## Operation
- States: IDLE (no owner) and OWNED (one owner).
- Registers: `Grant`, `ptr` (last owner index), `credit` (WeightW bits), `hold` ($clog2(MaxHold+1) bits).
- Pick: the first requesting agent searching from `ptr+1` upward, modulo NumOfAgents.
- IDLE: if `|In`, grant the picked agent, set `credit = Weight[pick]` (0 is treated as 1), clear `hold`, and go to OWNED. Otherwise stay in IDLE.
- OWNED, evaluated in priority order each cycle:
  1. `rst`.
  2. Release when `In[owner]==0`. `ptr` takes the owner index.
  3. Release when `MaxHold!=0` and `hold==MaxHold-1`. This pulses `TimeoutErr` and `ptr` takes the owner index.
  4. On `Done`:
     - Decrement `credit` and clear `hold`.
     - If `credit-1 > 0` and `In[owner]` is high, keep the grant.
     - Otherwise release, and `ptr` takes the owner index.
  5. Otherwise increment `hold`.
- On release, perform the pick in the same cycle with the updated `ptr`, excluding the departing owner only when the release was a timeout or a withdrawal.
  - If any agent is picked, grant it directly. There is no idle bubble, and state stays OWNED.
  - If none is picked, go to IDLE.
- If the departing agent is the only requester after a credit-exhausted `Done`, it is re-granted with fresh credit.
- `Done` while IDLE is ignored.
- Invariant: `Grant` is one-hot0, and `Grant[i]` implies `In[i]` was high at the granting edge.
- Reset values: `Grant=0`, `GrantIdx=0`, `TimeoutErr=0`, `ptr=NumOfAgents-1` (so agent 0 has first priority), `credit=0`, `hold=0`, state IDLE.

## Timing
- Request to grant latency: 1 cycle. `In` high at edge t in IDLE gives `Grant` high after edge t.
- `Done` sampled at edge t: the new owner's `Grant` rises and the old owner's falls at edge t, so the handoff has zero dead cycles.
- Withdrawal (`In[owner]` low at edge t): `Grant` for that agent drops at edge t.
- Timeout: with `MaxHold=M`, `Grant` drops at the M-th edge after grant (or after the last `Done`), with `TimeoutErr` high for the following cycle.
- Asserting `rst` mid-transaction clears `Grant` immediately and asynchronously. The first grant after reset release follows the IDLE rule.
- `Weight` changes affect only subsequent new grants.

## Structure
- Package `weighted_rr_arb_pkg` holds:
  - the state enum (IDLE, OWNED);
  - the function computing the rotated first-set index from (`req`, `ptr`);
  - localparams for the index and hold-counter widths.
- One sub-module, `rr_priority_pick`: purely combinational, inputs `req` vector and `ptr`, outputs `found` and `idx`. It is instantiated once.
- Everything else is a single always_ff with async reset plus next-state combinational logic, about 200 lines.

## Test plan
- Reset priority: `rst` held high for 5 cycles, then `In=4'b1111` and all weights 1.
  - Grants follow 0,1,2,3,0 on successive `Done` pulses, one `Done` per cycle.
  - There are no gaps.
- Weighting: `Weight={4'd1,4'd1,4'd3,4'd2}` (agents 3..0) and `In=4'b1111` held.
  - Grant sequence per `Done` is 0,0,1,1,1,2,3,0.
- Withdrawal: agent 1 is owner, `In=4'b1010`, and `In[1]` drops at edge t.
  - `Grant` goes from `4'b0010` to `4'b1000` at edge t.
  - `TimeoutErr` stays 0.
- Watchdog: `MaxHold=8`, agent 2 is granted alone, and no `Done` arrives.
  - `Grant[2]` drops 8 edges after grant.
  - `TimeoutErr` pulses exactly one cycle.
  - If `In[2]` is still high and no other agent requests, agent 2 is re-granted on the next edge.
- Sole requester and idle: `In=4'b0100` with weight 1, and three `Done` pulses.
  - `Grant` stays `4'b0100` continuously.
  - After `In=0`, `Grant=0` next edge, and a `Done` pulse while idle has no effect.
- Async reset mid-burst: assert `rst` between clock edges while agent 3 holds a grant with `credit=2`.
  - `Grant=0` before the next edge.
  - After release with `In=4'b1001`, agent 0 is granted first.
